alu_mult_seq: RTL and testbench
===============================

Name: alu_mult_seq

Overview:
- Multi-cycle multiply controller that drives the shared Hack-style ALU (x, y, zx, nx, zy, ny, f, no → out) to compute the low WIDTH bits of a×b by shift-and-add.
- Sits beside the CPU datapath. It owns the ALU port mux inputs while busy and presents a start/busy/done handshake to the requester.
- Low WIDTH bits are identical for signed (two's complement) and unsigned operands, so there is no sign mode.

Parameters:
- WIDTH, 16, operand/result/ALU data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  multiplicand; latched when start is accepted.
- b  input  WIDTH  multiplier; latched when start is accepted.
- busy  output  1  high from the cycle after acceptance through the DONE cycle.
- done  output  1  one-cycle pulse; product is valid.
- product  output  WIDTH  registered result; held until the next accepted start.
- product_zr  output  1  product == 0.
- product_ng  output  1  product[WIDTH-1].
- alu_x  output  WIDTH  ALU x operand.
- alu_y  output  WIDTH  ALU y operand.
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  ALU control bits.
- alu_out  input  WIDTH  ALU result; combinational, same cycle.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high, on port reset, clock port clk.
  - Reset (including mid-operation) forces IDLE. busy=0, done=0, product=0, internal acc/mcand/mplier/iter cleared.
  - product_zr=1 and product_ng=0 after reset.
- Internal registers: acc, mcand, mplier (WIDTH each); iter (clog2(WIDTH) bits).
- ALU codes: ADD = zx0 nx0 zy0 ny0 f1 no0 (x+y). ZERO = zx1 nx0 zy1 ny0 f1 no0 (constant 0).
- IDLE:
  - ALU outputs: alu_x=0, alu_y=0, ZERO code.
  - start=1 accepts the request: mcand<=a, mplier<=b, acc<=0, iter<=0.
  - If a==0 or b==0, go to DONE; otherwise go to ADD.
- ADD (1 cycle):
  - alu_x=acc, alu_y=mcand.
  - If mplier[0]=1, use the ADD code. Otherwise use ADD with zy=1 (x+0).
  - acc<=alu_out. Next state DBL.
- DBL (1 cycle):
  - alu_x=mcand, alu_y=mcand, ADD code.
  - mcand<=alu_out, mplier<=mplier>>1 (logical), iter<=iter+1.
  - Next state is DONE if (mplier>>1)==0 or iter==WIDTH-1; otherwise ADD.
- DONE (1 cycle):
  - product<=acc, done=1, ALU outputs as in IDLE. Next state IDLE.
  - A start asserted during DONE is ignored.
- busy=1 in ADD, DBL and DONE. start while busy is ignored and does not queue.
- Latency: let k = index of the highest set bit of b, plus 1.
  - done asserts 2k+1 cycles after the accepting edge.
  - If a==0 or b==0, done asserts 1 cycle after the accepting edge.
  - Maximum is 33 cycles for WIDTH=16.
- Arithmetic: all sums wrap modulo 2^WIDTH. There is no overflow flag.
- product_zr and product_ng are decoded from the product register, not from alu_out.
- Back-to-back operation: start may be asserted in the cycle after done. That IDLE cycle accepts it.

Test Plan:
- Reset, then a=3, b=5, start for 1 cycle → done exactly 7 cycles after the accepting edge; product=15, zr=0, ng=0; busy high for 7 cycles.
- a=0x1234, b=0 → done 1 cycle after acceptance; product=0, zr=1; alu_* stays at the ZERO code throughout.
- a=0xFFFF, b=0xFFFF (-1×-1) → done at cycle 33; product=0x0001. a=0xFFFD, b=7 → product=0xFFEB (-21), ng=1, done at cycle 7.
- a=300, b=300 → product=0x5F90 (90000 mod 65536), no error indication.
- Start a=3, b=5, then pulse start with a=9, b=9 in cycle 2 → second request ignored, product=15. Restart in the cycle after done with a=9, b=9 → product=81.
- a=0xFFFF, b=0xFFFF, assert reset at cycle 10 → next cycle busy=0, product=0, zr=1; no done pulse. A following a=2, b=3 run yields 6.

Source files
------------

// File: rtl/alu_mult_seq.sv
// Shift-and-add multiplier that drives the shared Hack ALU; returns the low WIDTH bits of a*b.
// done follows the accepting edge by 2k+1 cycles (k = index of b's top set bit + 1), or 1 cycle if either operand is 0; start is dropped while busy.
module alu_mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             product_zr,
    output logic             product_ng,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DBL,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_product;
    logic [IW-1:0]    r_iter;
    logic             r_busy;
    logic             r_done;

    logic             w_operand_zero;
    logic             w_last_iter;
    logic [WIDTH-1:0] w_mplier_shr;

    assign w_operand_zero = (a == '0) || (b == '0);
    assign w_mplier_shr   = r_mplier >> 1;
    // Stop once no multiplier bits remain; the iter bound only matters if that check never fires.
    assign w_last_iter    = (w_mplier_shr == '0) || (r_iter == IW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
            r_iter    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_iter   <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= w_operand_zero ? S_DONE : S_ADD;
                    end
                end
                S_ADD: begin
                    r_acc   <= alu_out;
                    r_state <= S_DBL;
                end
                S_DBL: begin
                    r_mcand  <= alu_out;
                    r_mplier <= w_mplier_shr;
                    r_iter   <= r_iter + 1'b1;
                    r_state  <= w_last_iter ? S_DONE : S_ADD;
                end
                S_DONE: begin
                    r_product <= r_acc;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ALU defaults to the constant-zero code whenever the multiplier is not stepping.
    always_comb begin
        alu_x  = '0;
        alu_y  = '0;
        alu_zx = 1'b1;
        alu_nx = 1'b0;
        alu_zy = 1'b1;
        alu_ny = 1'b0;
        alu_f  = 1'b1;
        alu_no = 1'b0;
        case (r_state)
            S_ADD: begin
                alu_x  = r_acc;
                alu_y  = r_mcand;
                alu_zx = 1'b0;
                alu_zy = ~r_mplier[0];
            end
            S_DBL: begin
                alu_x  = r_mcand;
                alu_y  = r_mcand;
                alu_zx = 1'b0;
                alu_zy = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign product    = r_product;
    assign product_zr = (r_product == '0);
    assign product_ng = r_product[WIDTH-1];

endmodule

// File: tb/tb_alu_mult_seq.sv
// Scoreboard bench for alu_mult_seq with a behavioural Hack ALU closing the loop.
// Expected product/latency are pushed on each accepted start and popped when done pulses.
module tb_alu_mult_seq;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] prod;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, product_zr, product_ng;
    logic [W-1:0] product, alu_x, alu_y, alu_out;
    logic         alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t_acc = 0;
    exp_t exp_q[$];

    alu_mult_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product),
        .product_zr(product_zr), .product_ng(product_ng),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
        .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural Hack ALU
    always_comb begin
        logic [W-1:0] xx, yy, oo;
        xx = alu_zx ? '0 : alu_x;
        xx = alu_nx ? ~xx : xx;
        yy = alu_zy ? '0 : alu_y;
        yy = alu_ny ? ~yy : yy;
        oo = alu_f ? (xx + yy) : (xx & yy);
        alu_out = alu_no ? ~oo : oo;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    function automatic int model_lat(input logic [W-1:0] ma, input logic [W-1:0] mb);
        int k = 0;
        if (ma == '0 || mb == '0) return 1;
        for (int i = 0; i < W; i++) if (mb[i]) k = i + 1;
        return 2 * k + 1;
    endfunction

    // Called at a negedge with the DUT idle; returns just after the accepting edge.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob);
        exp_t e;
        logic [2*W-1:0] full;
        full   = oa * ob;
        e.prod = full[W-1:0];
        e.lat  = model_lat(oa, ob);
        exp_q.push_back(e);
        start = 1'b1; a = oa; b = ob;
        @(posedge clk);
        #1;
        t_acc = cyc;
        start = 1'b0;
    endtask

    // Waits (bounded) for done; optionally injects a start pulse at iteration inj_at.
    task automatic wait_done(input int inj_at, input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input bit zcode);
        exp_t e;
        int   busy_n = 0;
        bit   seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (zcode) begin
                chk("zero_code", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'h2A);
                chk("zero_xy", {alu_x, alu_y}, 32'h0);
            end
            if (done) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", cyc - t_acc, e.lat);
                    chk("product", {16'd0, product}, {16'd0, e.prod});
                    chk("zr", {31'd0, product_zr}, {31'd0, e.prod == '0});
                    chk("ng", {31'd0, product_ng}, {31'd0, e.prod[W-1]});
                    chk("busy_cycles", busy_n, e.lat);
                end
            end else if (busy) begin
                busy_n++;
            end
            if (i == inj_at) begin
                start = 1'b1; a = ia; b = ib;
            end else if (i == inj_at + 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
    endtask

    initial begin
        int done_n;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_product", {16'd0, product}, 32'd0);
        chk("rst_zr", {31'd0, product_zr}, 32'd1);
        chk("rst_ng", {31'd0, product_ng}, 32'd0);
        chk("rst_alu_code", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'h2A);
        reset = 1'b0;
        @(negedge clk);

        run_op(16'd3, 16'd5);         wait_done(0, '0, '0, 1'b0);
        run_op(16'h1234, 16'd0);      wait_done(0, '0, '0, 1'b1);
        run_op(16'hFFFF, 16'hFFFF);   wait_done(0, '0, '0, 1'b0);
        run_op(16'hFFFD, 16'd7);      wait_done(0, '0, '0, 1'b0);
        run_op(16'd300, 16'd300);     wait_done(0, '0, '0, 1'b0);
        run_op(16'd0, 16'h8000);      wait_done(0, '0, '0, 1'b1);
        run_op(16'h0001, 16'h8000);   wait_done(0, '0, '0, 1'b0);

        // Start while busy must be dropped, then a back-to-back restart is accepted.
        run_op(16'd3, 16'd5);         wait_done(2, 16'd9, 16'd9, 1'b0);
        chk("no_queued_op", {31'd0, busy}, 32'd0);
        run_op(16'd9, 16'd9);         wait_done(0, '0, '0, 1'b0);

        // Reset partway through a long run.
        run_op(16'hFFFF, 16'hFFFF);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_product", {16'd0, product}, 32'd0);
        chk("midrst_zr", {31'd0, product_zr}, 32'd1);
        done_n = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        chk("midrst_no_done", done_n, 32'd0);

        run_op(16'd2, 16'd3);         wait_done(0, '0, '0, 1'b0);

        // Randomised operands against the model.
        for (int n = 0; n < 20; n++) begin
            run_op(16'($urandom), 16'($urandom_range(0, 16'hFFFF)));
            wait_done(0, '0, '0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
